// File: rtl/rf_multiport_pkg.sv
// Shared defaults and type aliases for the rf_multiport register file.
// Build option: RF_COMMIT_BYPASS_EN enables same-cycle commit-to-read forwarding.
package rf_multiport_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ROB_W_DEF    = 4;
  localparam int RI_W_DEF     = $clog2(NUM_REGS_DEF);

  typedef logic [XLEN_DEF-1:0]  data_t;
  typedef logic [ROB_W_DEF-1:0] tag_t;
  typedef logic [RI_W_DEF-1:0]  ridx_t;

endpackage

// File: rtl/rf_multiport_read_port.sv
// One operand read port: index mux, x0 masking and, with RF_COMMIT_BYPASS_EN,
// forwarding of a same-cycle commit that retires the register's pending tag.
module rf_read_port
  import rf_multiport_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ROB_W    = ROB_W_DEF,
  parameter int COMMIT_W = 2,
  parameter int RI_W     = $clog2(NUM_REGS)
) (
  input  logic                           i_en,
  input  logic [RI_W-1:0]                i_idx,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  i_val,
  input  logic [NUM_REGS-1:0]            i_busy,
  input  logic [NUM_REGS-1:0][ROB_W-1:0] i_tag,
  input  logic [COMMIT_W-1:0]            i_cm_valid,
  input  logic [COMMIT_W-1:0][RI_W-1:0]  i_cm_rd,
  input  logic [COMMIT_W-1:0][ROB_W-1:0] i_cm_tag,
  input  logic [COMMIT_W-1:0][XLEN-1:0]  i_cm_val,
  output logic [XLEN-1:0]                o_val,
  output logic                           o_busy,
  output logic [ROB_W-1:0]               o_tag
);

  logic            w_byp_hit;
  logic [XLEN-1:0] w_byp_val;

`ifdef RF_COMMIT_BYPASS_EN
  logic [COMMIT_W-1:0] w_lane_hit;

  // Youngest commit lane retiring the register's current tag supplies the operand.
  always_comb begin
    w_byp_hit = 1'b0;
    w_byp_val = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      w_lane_hit[k] = i_en && i_busy[i_idx] && i_cm_valid[k] &&
                      (i_cm_rd[k] == i_idx) && (i_cm_tag[k] == i_tag[i_idx]);
      w_byp_val     = w_lane_hit[k] ? i_cm_val[k] : w_byp_val;
      w_byp_hit     = w_byp_hit | w_lane_hit[k];
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{i_en, i_cm_valid, i_cm_rd, i_cm_tag, i_cm_val};
  assign w_byp_hit = 1'b0;
  assign w_byp_val = '0;
`endif

  assign o_val  = (i_idx == '0) ? '0   : (w_byp_hit ? w_byp_val : i_val[i_idx]);
  assign o_busy = (i_idx == '0) ? 1'b0 : (i_busy[i_idx] & ~w_byp_hit);
  assign o_tag  = (i_idx == '0) ? '0   : i_tag[i_idx];

endmodule

// File: rtl/rf_multiport.sv
// Renaming architectural register file with per-register busy bit and ROB tag.
// Build option: RF_COMMIT_BYPASS_EN forwards same-cycle commits to the read ports.
module rf_multiport
  import rf_multiport_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ROB_W    = ROB_W_DEF,
  parameter int RD_PORTS = 4,
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2,
  localparam int RI_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clr_in,
  input  logic [ISSUE_W-1:0]         iss_valid,
  input  logic [ISSUE_W*RI_W-1:0]    iss_rd,
  input  logic [ISSUE_W*ROB_W-1:0]   iss_tag,
  input  logic [COMMIT_W-1:0]        cm_valid,
  input  logic [COMMIT_W*RI_W-1:0]   cm_rd,
  input  logic [COMMIT_W*ROB_W-1:0]  cm_tag,
  input  logic [COMMIT_W*XLEN-1:0]   cm_val,
  input  logic [RD_PORTS*RI_W-1:0]   rd_idx,
  output logic [RD_PORTS*XLEN-1:0]   rd_val,
  output logic [RD_PORTS-1:0]        rd_busy,
  output logic [RD_PORTS*ROB_W-1:0]  rd_tag
);

  logic [ISSUE_W-1:0][RI_W-1:0]   w_iss_rd;
  logic [ISSUE_W-1:0][ROB_W-1:0]  w_iss_tag;
  logic [COMMIT_W-1:0][RI_W-1:0]  w_cm_rd;
  logic [COMMIT_W-1:0][ROB_W-1:0] w_cm_tag;
  logic [COMMIT_W-1:0][XLEN-1:0]  w_cm_val;
  logic [NUM_REGS-1:0][XLEN-1:0]  w_val;
  logic [NUM_REGS-1:0]            w_busy;
  logic [NUM_REGS-1:0][ROB_W-1:0] w_tag;

  assign w_iss_rd  = iss_rd;
  assign w_iss_tag = iss_tag;
  assign w_cm_rd   = cm_rd;
  assign w_cm_tag  = cm_tag;
  assign w_cm_val  = cm_val;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign w_val[g]  = '0;
      assign w_busy[g] = 1'b0;
      assign w_tag[g]  = '0;
    end else begin : g_arch
      logic [XLEN-1:0]  r_val, w_nval;
      logic             r_busy, w_nbusy, w_hit;
      logic [ROB_W-1:0] r_tag, w_ntag;

      // Commits write the value (youngest lane last) and may retire the tag; issues override busy/tag.
      always_comb begin
        w_nval = r_val;
        w_hit  = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
          w_nval = (cm_valid[k] && (w_cm_rd[k] == RI_W'(g))) ? w_cm_val[k] : w_nval;
          w_hit  = w_hit | (cm_valid[k] && (w_cm_rd[k] == RI_W'(g)) && (w_cm_tag[k] == r_tag));
        end
        w_nbusy = r_busy & ~w_hit & ~clr_in;
        w_ntag  = r_tag;
        for (int j = 0; j < ISSUE_W; j++) begin
          w_nbusy = (iss_valid[j] && (w_iss_rd[j] == RI_W'(g)) && !clr_in) ? 1'b1 : w_nbusy;
          w_ntag  = (iss_valid[j] && (w_iss_rd[j] == RI_W'(g)) && !clr_in) ? w_iss_tag[j] : w_ntag;
        end
      end

      // Register state: reset clears, rdy_in low holds.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          r_val  <= '0;
          r_busy <= 1'b0;
          r_tag  <= '0;
        end else if (rdy_in) begin
          r_val  <= w_nval;
          r_busy <= w_nbusy;
          r_tag  <= w_ntag;
        end
      end

      assign w_val[g]  = r_val;
      assign w_busy[g] = r_busy;
      assign w_tag[g]  = r_tag;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    rf_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .ROB_W    (ROB_W),
      .COMMIT_W (COMMIT_W),
      .RI_W     (RI_W)
    ) u_rd (
      .i_en       (rdy_in & ~rst_in),
      .i_idx      (rd_idx[p*RI_W +: RI_W]),
      .i_val      (w_val),
      .i_busy     (w_busy),
      .i_tag      (w_tag),
      .i_cm_valid (cm_valid),
      .i_cm_rd    (w_cm_rd),
      .i_cm_tag   (w_cm_tag),
      .i_cm_val   (w_cm_val),
      .o_val      (rd_val[p*XLEN +: XLEN]),
      .o_busy     (rd_busy[p]),
      .o_tag      (rd_tag[p*ROB_W +: ROB_W])
    );
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: directed scenarios plus randomized traffic
// against an array-based reference model (honours RF_COMMIT_BYPASS_EN).
module tb_rf_multiport;

  localparam int XLEN = 32, NUM_REGS = 32, ROB_W = 4, RD_PORTS = 4;
  localparam int ISSUE_W = 2, COMMIT_W = 2, RI_W = 5;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clr_in;
  logic [ISSUE_W-1:0]        iss_valid;
  logic [ISSUE_W*RI_W-1:0]   iss_rd;
  logic [ISSUE_W*ROB_W-1:0]  iss_tag;
  logic [COMMIT_W-1:0]       cm_valid;
  logic [COMMIT_W*RI_W-1:0]  cm_rd;
  logic [COMMIT_W*ROB_W-1:0] cm_tag;
  logic [COMMIT_W*XLEN-1:0]  cm_val;
  logic [RD_PORTS*RI_W-1:0]  rd_idx;
  logic [RD_PORTS*XLEN-1:0]  rd_val;
  logic [RD_PORTS-1:0]       rd_busy;
  logic [RD_PORTS*ROB_W-1:0] rd_tag;

  int n_cmp = 0;
  int n_err = 0;

  logic [XLEN-1:0]  m_val  [NUM_REGS];
  logic             m_busy [NUM_REGS];
  logic [ROB_W-1:0] m_tag  [NUM_REGS];

  rf_multiport dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .rd_idx(rd_idx), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1);
  end

  function automatic logic [XLEN-1:0] pv(input int p);
    return rd_val[p*XLEN +: XLEN];
  endfunction

  function automatic logic [ROB_W-1:0] pt(input int p);
    return rd_tag[p*ROB_W +: ROB_W];
  endfunction

  // Reference model: one clock edge computed from the rules, register by register.
  function automatic void model_step();
    if (rst_in) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
    end else if (rdy_in) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        logic hit;
        logic nb;
        logic [ROB_W-1:0] nt;
        hit = 1'b0;
        nt  = m_tag[r];
        for (int k = 0; k < COMMIT_W; k++) begin
          if (cm_valid[k] && int'(cm_rd[k*RI_W +: RI_W]) == r) begin
            m_val[r] = cm_val[k*XLEN +: XLEN];
            if (m_busy[r] && cm_tag[k*ROB_W +: ROB_W] == m_tag[r]) hit = 1'b1;
          end
        end
        nb = clr_in ? 1'b0 : (m_busy[r] && !hit);
        if (!clr_in) begin
          for (int j = 0; j < ISSUE_W; j++) begin
            if (iss_valid[j] && int'(iss_rd[j*RI_W +: RI_W]) == r) begin
              nb = 1'b1;
              nt = iss_tag[j*ROB_W +: ROB_W];
            end
          end
        end
        m_busy[r] = nb;
        m_tag[r]  = nt;
      end
    end
  endfunction

  function automatic void exp_read(input int idx, output logic [XLEN-1:0] v,
                                   output logic b, output logic [ROB_W-1:0] t);
    v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
`ifdef RF_COMMIT_BYPASS_EN
    if (rdy_in && !rst_in && m_busy[idx]) begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (cm_valid[k] && int'(cm_rd[k*RI_W +: RI_W]) == idx &&
            cm_tag[k*ROB_W +: ROB_W] == m_tag[idx]) begin
          v = cm_val[k*XLEN +: XLEN];
          b = 1'b0;
        end
      end
    end
`endif
    if (idx == 0) begin
      v = '0; b = 1'b0; t = '0;
    end
  endfunction

  task automatic clear_inputs();
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    iss_valid = '0; iss_rd = '0; iss_tag = '0;
    cm_valid = '0; cm_rd = '0; cm_tag = '0; cm_val = '0;
  endtask

  task automatic set_iss(input int l, input int rd, input int tag);
    iss_valid[l] = 1'b1;
    iss_rd[l*RI_W +: RI_W]    = RI_W'(rd);
    iss_tag[l*ROB_W +: ROB_W] = ROB_W'(tag);
  endtask

  task automatic set_cm(input int l, input int rd, input int tag, input logic [XLEN-1:0] v);
    cm_valid[l] = 1'b1;
    cm_rd[l*RI_W +: RI_W]    = RI_W'(rd);
    cm_tag[l*ROB_W +: ROB_W] = ROB_W'(tag);
    cm_val[l*XLEN +: XLEN]   = v;
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_idx[p*RI_W +: RI_W] = RI_W'(idx);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    for (int base = 0; base < NUM_REGS; base += RD_PORTS) begin
      for (int p = 0; p < RD_PORTS; p++) set_rd(p, base + p);
      @(negedge clk_in);
      for (int p = 0; p < RD_PORTS; p++) begin
        n_cmp++;
        if (pv(p) !== 32'h0 || rd_busy[p] !== 1'b0) begin
          n_err++;
          $display("FAIL reset x%0d: got val=%h busy=%b, want val=0 busy=0", base + p, pv(p), rd_busy[p]);
        end
      end
      tick();
    end
  endtask

  task automatic test_issue_commit();
    set_iss(0, 5, 3);
    tick();
    set_rd(0, 5);
    @(negedge clk_in);
    n_cmp++;
    if (rd_busy[0] !== 1'b1 || pt(0) !== 4'd3) begin
      n_err++;
      $display("FAIL issue_x5: got busy=%b tag=%0d, want busy=1 tag=3", rd_busy[0], pt(0));
    end
    tick();
    set_cm(0, 5, 3, 32'hDEAD);
    @(negedge clk_in);
    n_cmp++;
`ifdef RF_COMMIT_BYPASS_EN
    if (rd_busy[0] !== 1'b0 || pv(0) !== 32'hDEAD) begin
      n_err++;
      $display("FAIL commit_bypass_x5: got busy=%b val=%h, want busy=0 val=0000dead", rd_busy[0], pv(0));
    end
`else
    if (rd_busy[0] !== 1'b1 || pt(0) !== 4'd3) begin
      n_err++;
      $display("FAIL commit_samecycle_x5: got busy=%b tag=%0d, want busy=1 tag=3", rd_busy[0], pt(0));
    end
`endif
    tick();
    @(negedge clk_in);
    n_cmp++;
    if (rd_busy[0] !== 1'b0 || pv(0) !== 32'hDEAD) begin
      n_err++;
      $display("FAIL commit_after_x5: got busy=%b val=%h, want busy=0 val=0000dead", rd_busy[0], pv(0));
    end
    tick();
  endtask

  task automatic test_issue_beats_commit();
    set_iss(0, 7, 2);
    tick();
    set_cm(0, 7, 2, 32'h77);
    set_iss(0, 7, 9);
    tick();
    set_rd(0, 7);
    @(negedge clk_in);
    n_cmp++;
    if (rd_busy[0] !== 1'b1 || pt(0) !== 4'd9 || pv(0) !== 32'h77) begin
      n_err++;
      $display("FAIL issue_beats_commit: got busy=%b tag=%0d val=%h, want busy=1 tag=9 val=00000077",
               rd_busy[0], pt(0), pv(0));
    end
    tick();
  endtask

  task automatic test_lane_priority();
    set_iss(0, 4, 1);
    set_iss(1, 4, 6);
    tick();
    set_rd(1, 4);
    @(negedge clk_in);
    n_cmp++;
    if (rd_busy[1] !== 1'b1 || pt(1) !== 4'd6) begin
      n_err++;
      $display("FAIL issue_lane_prio: got busy=%b tag=%0d, want busy=1 tag=6", rd_busy[1], pt(1));
    end
    tick();
    set_cm(0, 4, 0, 32'h11);
    set_cm(1, 4, 1, 32'h22);
    tick();
    @(negedge clk_in);
    n_cmp++;
    if (pv(1) !== 32'h22 || rd_busy[1] !== 1'b1 || pt(1) !== 4'd6) begin
      n_err++;
      $display("FAIL commit_lane_prio: got val=%h busy=%b tag=%0d, want val=00000022 busy=1 tag=6",
               pv(1), rd_busy[1], pt(1));
    end
    tick();
  endtask

  task automatic test_clr();
    set_iss(0, 3, 1);
    set_iss(1, 8, 2);
    tick();
    clr_in = 1'b1;
    set_iss(0, 9, 4);
    set_cm(0, 3, 5, 32'h5);
    tick();
    set_rd(0, 3); set_rd(1, 8); set_rd(2, 9); set_rd(3, 4);
    @(negedge clk_in);
    n_cmp++;
    if (pv(0) !== 32'h5 || rd_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL clr_x3: got val=%h busy=%b, want val=00000005 busy=0", pv(0), rd_busy[0]);
    end
    for (int p = 1; p < RD_PORTS; p++) begin
      n_cmp++;
      if (rd_busy[p] !== 1'b0) begin
        n_err++;
        $display("FAIL clr_busy_p%0d: got busy=%b, want busy=0", p, rd_busy[p]);
      end
    end
    tick();
  endtask

  task automatic test_rdy_low();
    set_iss(0, 10, 7);
    tick();
    rdy_in = 1'b0;
    clr_in = 1'b1;
    set_iss(1, 11, 3);
    set_cm(0, 4, 0, 32'h99);
    tick();
    set_rd(0, 10); set_rd(1, 11); set_rd(2, 4); set_rd(3, 0);
    @(negedge clk_in);
    n_cmp++;
    if (rd_busy[0] !== 1'b1 || pt(0) !== 4'd7) begin
      n_err++;
      $display("FAIL rdy_low_x10: got busy=%b tag=%0d, want busy=1 tag=7", rd_busy[0], pt(0));
    end
    n_cmp++;
    if (rd_busy[1] !== 1'b0 || pv(1) !== 32'h0) begin
      n_err++;
      $display("FAIL rdy_low_x11: got busy=%b val=%h, want busy=0 val=0", rd_busy[1], pv(1));
    end
    n_cmp++;
    if (pv(2) !== 32'h22) begin
      n_err++;
      $display("FAIL rdy_low_x4: got val=%h, want val=00000022", pv(2));
    end
    tick();
  endtask

  task automatic test_x0();
    for (int p = 0; p < RD_PORTS; p++) set_rd(p, 0);
    set_iss(0, 0, 5);
    set_iss(1, 0, 6);
    set_cm(0, 0, 5, 32'hFFFF);
    set_cm(1, 0, 6, 32'hEEEE);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_in);
      for (int p = 0; p < RD_PORTS; p++) begin
        n_cmp++;
        if (pv(p) !== 32'h0 || rd_busy[p] !== 1'b0 || pt(p) !== 4'h0) begin
          n_err++;
          $display("FAIL x0_c%0d_p%0d: got val=%h busy=%b tag=%0d, want 0/0/0", c, p, pv(p), rd_busy[p], pt(p));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0]  ev;
    logic             eb;
    logic [ROB_W-1:0] et;
    rst_in = 1'b1;
    tick();
    for (int c = 0; c < 400; c++) begin
      rst_in = ($urandom_range(0, 99) == 0);
      rdy_in = ($urandom_range(0, 7) != 0);
      clr_in = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < ISSUE_W; j++) begin
        if ($urandom_range(0, 1) == 1) set_iss(j, $urandom_range(0, 7), $urandom_range(0, 15));
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        int rd;
        rd = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1)
          set_cm(k, rd, ($urandom_range(0, 3) != 0) ? int'(m_tag[rd]) : $urandom_range(0, 15), $urandom);
      end
      if (cm_valid == 2'b11 && cm_tag[ROB_W-1:0] == cm_tag[2*ROB_W-1:ROB_W]) cm_valid[1] = 1'b0;
      for (int p = 0; p < RD_PORTS; p++) set_rd(p, $urandom_range(0, 9));
      @(negedge clk_in);
      for (int p = 0; p < RD_PORTS; p++) begin
        exp_read(int'(rd_idx[p*RI_W +: RI_W]), ev, eb, et);
        n_cmp++;
        if (pv(p) !== ev || rd_busy[p] !== eb || (eb && pt(p) !== et)) begin
          n_err++;
          $display("FAIL random c%0d p%0d x%0d: got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                   c, p, rd_idx[p*RI_W +: RI_W], pv(p), rd_busy[p], pt(p), ev, eb, et);
        end
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rd_idx = '0;
    @(posedge clk_in);
    #1;
    test_reset();
    test_issue_commit();
    test_issue_beats_commit();
    test_lane_priority();
    test_clr();
    test_rdy_low();
    test_x0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
